// File: rtl/uart_tx_num_msg.sv
// UART message sender: prints PREFIX, the decimal value of a latched binary number,
// and an optional CR LF over an 8N1 line, with inter-byte flow control.
module uart_tx_num_msg #(
  parameter int CLK_PER_BIT = 434,
  parameter int PREFIX_LEN  = 6,
  parameter logic [8*PREFIX_LEN-1:0] PREFIX = "Time: ",
  parameter int VAL_W       = 16,
  parameter int DIGITS      = 5,
  parameter int ZPAD        = 0,
  parameter int NEWLINE     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic [VAL_W-1:0] value,
  input  logic             block,
  output logic             busy,
  output logic             done,
  output logic             tx
);
  localparam int CW      = $clog2(CLK_PER_BIT);
  localparam int MSG_END = PREFIX_LEN + DIGITS + ((NEWLINE != 0) ? 2 : 0);

  typedef enum logic [2:0] {IDLE, CONVERT, PICK, START, DATA, STOP} state_t;

  state_t              state;
  logic [CW-1:0]       clk_cnt;
  logic [5:0]          bit_cnt;
  logic [5:0]          idx;
  logic [VAL_W-1:0]    val_sh;
  logic [4*DIGITS-1:0] bcd, bcd_adj;
  logic [7:0]          tx_sh, cur_byte;
  logic [5:0]          lead_skip, next_raw, next_idx;
  logic                more, bit_end;

  // Double-dabble add-3 step; the shift drops the top carry, giving value mod 10^DIGITS.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++)
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
  end

  // Number of leading zero digits to jump over; the units digit is never skipped.
  always_comb begin
    lead_skip = 6'(DIGITS - 1);
    for (int d = 0; d < DIGITS; d++)
      if (bcd[4*d +: 4] != 4'd0) lead_skip = 6'(DIGITS - 1 - d);
  end

  always_comb begin
    cur_byte = 8'h0A;
    if (int'(idx) < PREFIX_LEN)
      cur_byte = PREFIX[8*(PREFIX_LEN-1-int'(idx)) +: 8];
    else if (int'(idx) < PREFIX_LEN + DIGITS)
      cur_byte = 8'h30 + {4'h0, bcd[4*(PREFIX_LEN+DIGITS-1-int'(idx)) +: 4]};
    else if (int'(idx) == PREFIX_LEN + DIGITS)
      cur_byte = 8'h0D;
  end

  assign next_raw = idx + 6'd1;
  assign next_idx = (ZPAD == 0 && next_raw == 6'(PREFIX_LEN)) ? next_raw + lead_skip : next_raw;
  assign more     = int'(idx) < MSG_END;
  assign bit_end  = clk_cnt == CW'(CLK_PER_BIT - 1);

  // tx is registered from the current state, so the line lags the state by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      idx     <= '0;
      val_sh  <= '0;
      bcd     <= '0;
      tx_sh   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (send) begin
            val_sh  <= value;
            bcd     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          bcd    <= (bcd_adj << 1) | {{(4*DIGITS-1){1'b0}}, val_sh[VAL_W-1]};
          val_sh <= val_sh << 1;
          if (bit_cnt == 6'(VAL_W - 1)) begin
            bit_cnt <= '0;
            idx     <= '0;
            state   <= PICK;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        PICK: begin
          tx <= 1'b1;
          if (!more) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (!block) begin
            tx_sh   <= cur_byte;
            idx     <= next_idx;
            clk_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          tx <= tx_sh[0];
          if (bit_end) begin
            clk_cnt <= '0;
            tx_sh   <= tx_sh >> 1;
            if (bit_cnt == 6'd7) state <= STOP;
            else bit_cnt <= bit_cnt + 6'd1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= PICK;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
